// File: rtl/serial_pkt_rx.sv
// Byte-to-frame receiver: SYNC, LEN, payload, CHK; releases verified payloads as a valid/ready stream.
// Optional PKT_ERR_CNT_EN adds a saturating error counter on err_count (constant 0 when undefined).
module serial_pkt_rx #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 52080
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_new,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] err_count
);
    // state   | meaning
    // HUNT    | waiting for SYNC_BYTE
    // LEN     | expecting length byte
    // PAYLOAD | buffering payload bytes
    // CHECK   | expecting checksum byte
    // SEND    | streaming verified payload out
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMR_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHECK, S_SEND} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_buf [MAX_LEN];
    logic [7:0]       r_len;
    logic [7:0]       r_sum;
    logic [IDX_W-1:0] r_widx;
    logic [IDX_W-1:0] r_ridx;
    logic [TMR_W-1:0] r_tmr;
    logic             r_frame_ok;
    logic             r_frame_err;
    logic [1:0]       r_err_code;

    logic       w_in_frame;
    logic       w_timeout;
    logic       w_len_bad;
    logic [7:0] w_sum_nxt;
    logic       w_sum_ok;
    logic       w_wlast;
    logic       w_rlast;
    logic       w_hs;
    logic       w_err;
    logic [1:0] w_err_cause;

    assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign w_timeout  = w_in_frame && !rx_new && (r_tmr == TMR_LAST);
    assign w_len_bad  = (rx_data == 8'h00) || (rx_data > MAX_LEN_B);
    assign w_sum_nxt  = r_sum + rx_data;
    assign w_sum_ok   = (w_sum_nxt == 8'h00);
    assign w_wlast    = (8'(r_widx) == (r_len - 8'd1));
    assign w_rlast    = (8'(r_ridx) == (r_len - 8'd1));
    assign w_hs       = (r_state == S_SEND) && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_HUNT;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HUNT:    if (rx_new && rx_data == SYNC_BYTE) w_state_nxt = S_LEN;
            S_LEN:     if (rx_new)         w_state_nxt = w_len_bad ? S_HUNT : S_PAYLOAD;
                       else if (w_timeout) w_state_nxt = S_HUNT;
            S_PAYLOAD: if (rx_new && w_wlast) w_state_nxt = S_CHECK;
                       else if (w_timeout)    w_state_nxt = S_HUNT;
            S_CHECK:   if (rx_new)         w_state_nxt = w_sum_ok ? S_SEND : S_HUNT;
                       else if (w_timeout) w_state_nxt = S_HUNT;
            S_SEND:    if (w_hs && w_rlast) w_state_nxt = S_HUNT;
            default:   w_state_nxt = S_HUNT;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        if (r_state == S_SEND) begin
            out_valid = 1'b1;
            out_data  = r_buf[r_ridx];
            out_last  = w_rlast;
        end
    end

    always_comb begin
        w_err       = 1'b0;
        w_err_cause = 2'd0;
        if (w_timeout) begin
            w_err       = 1'b1;
            w_err_cause = 2'd2;
        end else if (rx_new) begin
            case (r_state)
                S_LEN:   if (w_len_bad) w_err = 1'b1;
                S_CHECK: if (!w_sum_ok) begin w_err = 1'b1; w_err_cause = 2'd1; end
                S_SEND:  begin w_err = 1'b1; w_err_cause = 2'd3; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_len       <= 8'h00;
            r_sum       <= 8'h00;
            r_widx      <= '0;
            r_ridx      <= '0;
            r_tmr       <= '0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_frame_ok  <= (r_state == S_CHECK) && rx_new && w_sum_ok;
            r_frame_err <= w_err;
            if (w_err) r_err_code <= w_err_cause;
            if (!w_in_frame || rx_new || w_timeout) r_tmr <= '0;
            else                                    r_tmr <= r_tmr + 1'b1;
            case (r_state)
                S_LEN: if (rx_new && !w_len_bad) begin
                    r_len  <= rx_data;
                    r_sum  <= rx_data;
                    r_widx <= '0;
                end
                S_PAYLOAD: if (rx_new) begin
                    r_sum  <= w_sum_nxt;
                    r_widx <= r_widx + 1'b1;
                end
                S_CHECK: r_ridx <= '0;
                S_SEND:  if (w_hs) r_ridx <= r_ridx + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_PAYLOAD && rx_new) r_buf[r_widx] <= rx_data;
    end

    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;

`ifdef PKT_ERR_CNT_EN
    logic [7:0] r_err_count;
    always_ff @(posedge clk) begin
        if (!rst)                             r_err_count <= 8'h00;
        else if (w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end
    assign err_count = r_err_count;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_serial_pkt_rx.sv
// Self-checking bench for serial_pkt_rx: frame table plus timeout, backpressure/overrun and reset sequences.
module tb_serial_pkt_rx;
    localparam int T    = 20;
    localparam int MAXL = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_new;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    serial_pkt_rx #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAXL), .TIMEOUT_CLKS(T)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_new(rx_new),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .err_count(err_count)
    );

    typedef struct {
        logic [159:0] b;
        int           n;
        bit           ok;
        logic [1:0]   code;
        int           poff;
    } rec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } sb_t;

    rec_t       tbl [8];
    sb_t        sb [$];
    int         n_pass = 0;
    int         n_total = 0;
    int         ok_seen = 0;
    int         err_seen = 0;
    int         pops = 0;
    logic [1:0] last_code = 2'd0;
    bit         done = 1'b0;
    int         exp_errs = 0;
    logic [1:0] exp_code = 2'd0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic       prev_l = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic set_rec(input int k, input logic [159:0] v, input int n, input bit ok,
                           input logic [1:0] code, input int poff);
        tbl[k].b    = v << (160 - 8 * n);
        tbl[k].n    = n;
        tbl[k].ok   = ok;
        tbl[k].code = code;
        tbl[k].poff = poff;
    endtask

    function automatic logic [7:0] fb(input rec_t r, input int i);
        return r.b[159 - 8 * i -: 8];
    endfunction

    function automatic logic [7:0] exp_cnt();
`ifdef PKT_ERR_CNT_EN
        return (exp_errs > 255) ? 8'hFF : 8'(exp_errs);
`else
        return 8'h00;
`endif
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_new  = 1'b1;
        @(posedge clk); #1;
        rx_new  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        sb_t e;
        e.d = d;
        e.l = l;
        sb.push_back(e);
    endtask

    task automatic check_state(input string name);
        chk({name, "_err_code"}, err_code, exp_code);
        chk({name, "_err_count"}, err_count, exp_cnt());
        chk({name, "_sb_drained"}, sb.size(), 0);
    endtask

    task automatic process_rec(input int k);
        rec_t r;
        int   bo;
        int   be;
        int   plen;
        r    = tbl[k];
        bo   = ok_seen;
        be   = err_seen;
        plen = r.n - r.poff - 1;
        if (r.ok)
            for (int i = 0; i < plen; i++) push_byte(fb(r, r.poff + i), (i == plen - 1));
        for (int i = 0; i < r.n; i++) send_byte(fb(r, i));
        idle(40);
        chk($sformatf("rec%0d_frame_ok", k), ok_seen - bo, r.ok);
        chk($sformatf("rec%0d_frame_err", k), err_seen - be, !r.ok);
        if (!r.ok) begin
            chk($sformatf("rec%0d_code", k), last_code, r.code);
            exp_errs++;
            exp_code = r.code;
        end
        check_state($sformatf("rec%0d", k));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bo, be, bp;
        rst       = 1'b0;
        rx_new    = 1'b0;
        rx_data   = 8'h00;
        out_ready = 1'b1;

        set_rec(0, 48'hA5_03_11_22_33_97, 6, 1'b1, 2'd0, 2);
        set_rec(1, 48'hA5_03_11_22_33_98, 6, 1'b0, 2'd1, 2);
        set_rec(2, 16'hA5_00, 2, 1'b0, 2'd0, 2);
        set_rec(3, 16'hA5_11, 2, 1'b0, 2'd0, 2);
        set_rec(4, 32'hA5_01_00_FF, 4, 1'b1, 2'd0, 2);
        set_rec(5, 56'h00_12_A5_02_A5_A5_B4, 7, 1'b1, 2'd0, 4);
        set_rec(6, 152'hA5_10_01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10_68, 19, 1'b1, 2'd0, 2);
        set_rec(7, 16'hA5_FF, 2, 1'b0, 2'd0, 2);

        fork
            begin
                while (!done) begin
                    @(negedge clk);
                    if (rst) begin
                        if (frame_ok || frame_err) begin
                            chk("ok_err_exclusive", frame_ok & frame_err, 0);
                            if (frame_ok) ok_seen++;
                            if (frame_err) begin
                                err_seen++;
                                last_code = err_code;
                            end
                        end
                        if (prev_stall) begin
                            chk("stall_valid", out_valid, 1);
                            chk("stall_data", out_data, prev_d);
                            chk("stall_last", out_last, prev_l);
                        end
                        if (out_valid && out_ready) begin
                            if (sb.size() == 0) chk("sb_expected_byte", sb.size(), 1);
                            else begin
                                sb_t e;
                                e = sb.pop_front();
                                chk("out_data", out_data, e.d);
                                chk("out_last", out_last, e.l);
                            end
                            pops++;
                        end
                        prev_stall = out_valid && !out_ready;
                        prev_d     = out_data;
                        prev_l     = out_last;
                    end else begin
                        prev_stall = 1'b0;
                    end
                end
            end
            begin
                idle(3);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_last", out_last, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_frame_ok", frame_ok, 0);
                chk("rst_frame_err", frame_err, 0);
                chk("rst_err_code", err_code, 0);
                chk("rst_err_count", err_count, 0);
                rst = 1'b1;
                idle(2);

                for (int k = 0; k < 8; k++) process_rec(k);

                // Timeout: third byte never followed.
                be = err_seen;
                send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
                idle(T + 10);
                chk("tmo_frame_err", err_seen - be, 1);
                chk("tmo_code", last_code, 2);
                exp_errs++;
                exp_code = 2'd2;
                check_state("tmo");

                // Checksum byte lands exactly on the expiry cycle.
                bo = ok_seen;
                be = err_seen;
                push_byte(8'h11, 1'b0);
                push_byte(8'h22, 1'b1);
                send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
                idle(T - 2);
                send_byte(8'hCB);
                idle(20);
                chk("tmo_edge_ok", ok_seen - bo, 1);
                chk("tmo_edge_err", err_seen - be, 0);
                check_state("tmo_edge");

                // Backpressure with an overrun byte injected during SEND.
                bo = ok_seen;
                be = err_seen;
                bp = pops;
                push_byte(8'h01, 1'b0);
                push_byte(8'h02, 1'b0);
                push_byte(8'h03, 1'b0);
                push_byte(8'h04, 1'b1);
                fork
                    begin
                        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
                        send_byte(8'h03); send_byte(8'h04); send_byte(8'hF2); send_byte(8'h55);
                    end
                    begin
                        repeat (40) begin
                            @(posedge clk); #1;
                            out_ready = ~out_ready;
                        end
                    end
                join
                out_ready = 1'b1;
                idle(10);
                chk("bp_handshakes", pops - bp, 4);
                chk("bp_frame_ok", ok_seen - bo, 1);
                chk("ovr_frame_err", err_seen - be, 1);
                chk("ovr_code", last_code, 3);
                exp_errs++;
                exp_code = 2'd3;
                check_state("bp");

                // Reset after the second output byte.
                bp = pops;
                push_byte(8'hA1, 1'b0);
                push_byte(8'hB2, 1'b0);
                push_byte(8'hC3, 1'b0);
                push_byte(8'hD4, 1'b1);
                send_byte(8'hA5); send_byte(8'h04); send_byte(8'hA1); send_byte(8'hB2);
                send_byte(8'hC3); send_byte(8'hD4); send_byte(8'h12);
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk); #1;
                    if (pops >= bp + 2) break;
                end
                rst = 1'b0;
                @(posedge clk); #1;
                chk("rstsend_pops", pops - bp, 2);
                chk("rstsend_out_valid", out_valid, 0);
                chk("rstsend_err_code", err_code, 0);
                chk("rstsend_err_count", err_count, 0);
                rst = 1'b1;
                sb.delete();
                exp_errs = 0;
                exp_code = 2'd0;
                idle(2);
                process_rec(0);

                done = 1'b1;
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/serial_pkt_rx.md
Name: serial_pkt_rx

Overview:
- Byte-to-frame stage directly downstream of the UART receiver; consumes its `data[7:0]` and single-cycle `new_data` strobe.
- Hunts for a sync byte, takes a length byte, buffers the payload, and checks an 8-bit checksum.
- Releases each verified payload as a valid/ready byte stream with a last-byte marker.
- Corrupt, truncated or overflowing frames are discarded and reported.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload bytes (1..255); sets buffer depth.
- TIMEOUT_CLKS, 52080, max clocks between bytes inside a frame (default ≈10 bit times at CLK_PER_BIT 5208).

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-low (asserted when 0)
- `rx_data`  in  8  byte from UART receiver
- `rx_new`  in  1  one-cycle strobe; `rx_data` valid this cycle
- `out_data`  out  8  payload byte
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accepts byte when `out_valid` & `out_ready`
- `out_last`  out  1  qualifies final payload byte of frame
- `frame_ok`  out  1  one-cycle pulse: frame verified and released
- `frame_err`  out  1  one-cycle pulse: error detected
- `err_code`  out  2  cause, held until next `frame_err`: 0 bad LEN, 1 checksum, 2 timeout, 3 overrun
- `err_count`  out  8  saturating error count (see Optional Feature)

Behaviour:

Frame format: SYNC, LEN, LEN payload bytes, CHK. A frame is valid when (LEN + payload bytes + CHK) mod 256 == 0.

Reset (`rst`=0 at `clk` edge):
- state=HUNT.
- `out_valid`, `out_last`, `frame_ok`, `frame_err` = 0; `err_code`=0; `err_count`=0; `out_data`=0.
- Byte and timeout counters cleared.
- Reset mid-frame or mid-SEND drops the frame; `out_valid` is low the cycle after reset.

States:
- HUNT: on `rx_new` with `rx_data`==SYNC_BYTE → LEN. Other bytes are ignored silently.
- LEN: on `rx_new`:
  - LEN==0 or LEN>MAX_LEN → `frame_err`, code 0, → HUNT.
  - Else latch LEN, seed running sum with LEN, clear write index → PAYLOAD.
- PAYLOAD: on `rx_new`:
  - Write byte at index, add it to sum, index+1.
  - When index reaches LEN → CHECK.
  - A byte equal to SYNC_BYTE is treated as data.
- CHECK: on `rx_new`:
  - (sum + `rx_data`) mod 256 == 0 → `frame_ok` pulse next cycle, `out_valid`=1 same cycle, read index=0 → SEND.
  - Else `frame_err` code 1 → HUNT.
- SEND:
  - `out_data` = buf[read index]; `out_last` = (read index == LEN-1).
  - On handshake, read index+1.
  - Handshake with `out_last` → `out_valid`=0, → HUNT next cycle.
  - `out_data` and `out_last` are stable while `out_valid` & !`out_ready`.

Timeout (states LEN, PAYLOAD, CHECK only):
- Counter clears on entry and on every `rx_new`; otherwise increments.
- On reaching TIMEOUT_CLKS-1 without `rx_new` → `frame_err` code 2, → HUNT.
- `rx_new` in the expiry cycle wins: the byte is processed and the counter clears.

Overrun:
- `rx_new` during SEND → byte dropped, `frame_err` code 3, stay in SEND; output stream is unaffected.

Arithmetic and latency:
- Sum is 8-bit, wraps modulo 256.
- Buffer index width is $clog2(MAX_LEN).
- Latency from CHK strobe to first `out_valid` is 1 clock.
- `frame_ok` and `frame_err` are never asserted in the same cycle.

Optional Feature:
- Macro PKT_ERR_CNT_EN.
- Defined: `err_count` increments on every `frame_err` pulse, saturates at 255, and is cleared only by reset.
- Undefined: counter logic is omitted and `err_count` is constant 0.

Test Plan:
- Good frame: bytes A5 03 11 22 33 97, `out_ready`=1 → `frame_ok` pulse; `out_data` 11, 22, 33 on consecutive cycles; `out_last` only with 33; return to HUNT.
- Bad checksum: A5 03 11 22 33 98 → `frame_err`, `err_code`=1, `out_valid` never rises, `err_count`=1 (macro on).
- Bad length: A5 00, then A5 11 (MAX_LEN 16) → two `frame_err` pulses, code 0; then a following good frame is accepted.
- Timeout: A5 02 11, then idle TIMEOUT_CLKS clocks → `frame_err` code 2. Repeat with 5th byte landing exactly on the expiry cycle → no error.
- Backpressure and overrun: good 4-byte frame, `out_ready` toggled 0/1 every cycle → 4 handshakes, data held during stalls. Inject `rx_new`=55 during SEND → `frame_err` code 3, payload output unchanged.
- Reset mid-SEND: `rst`=0 after 2nd output byte → `out_valid`=0 next cycle, state HUNT, `err_code`=0.
